// File: rtl/bebida_pkg.sv
// Shared definitions for the drink sequencer: stage encoding, time width and drink codes.
package bebida_pkg;

  localparam int T_W = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AGUA      = 3'd1,
    CAFE      = 3'd2,
    LECHE     = 3'd3,
    CHOCOLATE = 3'd4,
    AZUCAR    = 3'd5,
    DONE      = 3'd6
  } estado_t;

  localparam logic [2:0] CAFE_NEGRO = 3'b001;
  localparam logic [2:0] CAFE_LECHE = 3'b010;
  localparam logic [2:0] CAPUCHINO  = 3'b011;
  localparam logic [2:0] MOCACHINO  = 3'b100;

  function automatic logic selValida(input logic [2:0] s);
    return (s == CAFE_NEGRO) || (s == CAFE_LECHE) || (s == CAPUCHINO) || (s == MOCACHINO);
  endfunction

endpackage

// File: rtl/contador_etapa.sv
// Per-stage remaining-time counter; `last` flags the tick that finishes the stage.
module contador_etapa
  import bebida_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [T_W-1:0] value,
  input  logic           tick,
  output logic [T_W-1:0] rem,
  output logic           last
);

  logic [T_W-1:0] r_rem;

  // A final tick does not decrement: the stage changes instead and the next load takes over.
  always_ff @(posedge clk) begin
    if (rst)
      r_rem <= '0;
    else if (load)
      r_rem <= value;
    else if (tick && (r_rem > T_W'(1)))
      r_rem <= r_rem - T_W'(1);
  end

  assign rem  = r_rem;
  assign last = tick && (r_rem == T_W'(1));

endmodule

// File: rtl/secuenciador_bebida.sv
// Drink dispensing sequencer: walks the five ingredient stages using latched per-drink times.
module secuenciador_bebida
  import bebida_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cancel,
  input  logic           tick,
  input  logic [2:0]     sel,
  input  logic [T_W-1:0] t_agua,
  input  logic [T_W-1:0] t_cafe,
  input  logic [T_W-1:0] t_leche,
  input  logic [T_W-1:0] t_chocolate,
  input  logic [T_W-1:0] t_azucar,
  output logic           v_agua,
  output logic           v_cafe,
  output logic           v_leche,
  output logic           v_chocolate,
  output logic           v_azucar,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2:0]     etapa
);

  estado_t        r_estado, w_sig;
  logic [T_W-1:0] r_tAgua, r_tCafe, r_tLeche, r_tChocolate, r_tAzucar;
  logic [2:0]     r_sel;
  logic           r_entry, r_err;
  logic           w_acepta, w_load, w_last, w_avanza;
  logic [T_W-1:0] w_valor, w_rem;

  assign w_acepta = (r_estado == IDLE) && start && selValida(sel);
  // A zero-time stage loads rem=0 and leaves after its single cycle.
  assign w_avanza = (w_rem == '0) || w_last;

  contador_etapa u_contador (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_valor),
    .tick  (tick && !r_entry),
    .rem   (w_rem),
    .last  (w_last)
  );

  always_comb begin
    w_sig   = r_estado;
    w_load  = 1'b0;
    w_valor = '0;
    case (r_estado)
      IDLE: begin
        if (w_acepta) begin
          w_sig   = AGUA;
          w_load  = 1'b1;
          w_valor = t_agua;
        end
      end
      AGUA, CAFE, LECHE, CHOCOLATE, AZUCAR: begin
        // Cancel wins over a simultaneous final tick.
        if (cancel || !selValida(r_sel)) begin
          w_sig = IDLE;
        end else if (w_avanza) begin
          w_load = 1'b1;
          case (r_estado)
            AGUA:      begin w_sig = CAFE;      w_valor = r_tCafe;      end
            CAFE:      begin w_sig = LECHE;     w_valor = r_tLeche;     end
            LECHE:     begin w_sig = CHOCOLATE; w_valor = r_tChocolate; end
            CHOCOLATE: begin w_sig = AZUCAR;    w_valor = r_tAzucar;    end
            default:   begin w_sig = DONE;      w_load  = 1'b0;         end
          endcase
        end
      end
      DONE:    w_sig = IDLE;
      default: w_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado     <= IDLE;
      r_entry      <= 1'b0;
      r_err        <= 1'b0;
      r_sel        <= '0;
      r_tAgua      <= '0;
      r_tCafe      <= '0;
      r_tLeche     <= '0;
      r_tChocolate <= '0;
      r_tAzucar    <= '0;
    end else begin
      r_estado <= w_sig;
      r_entry  <= w_load;
      r_err    <= (r_estado == IDLE) && start && !selValida(sel);
      if (w_acepta) begin
        r_sel        <= sel;
        r_tAgua      <= t_agua;
        r_tCafe      <= t_cafe;
        r_tLeche     <= t_leche;
        r_tChocolate <= t_chocolate;
        r_tAzucar    <= t_azucar;
      end
    end
  end

  assign v_agua      = (r_estado == AGUA)      && (w_rem != '0);
  assign v_cafe      = (r_estado == CAFE)      && (w_rem != '0);
  assign v_leche     = (r_estado == LECHE)     && (w_rem != '0);
  assign v_chocolate = (r_estado == CHOCOLATE) && (w_rem != '0);
  assign v_azucar    = (r_estado == AZUCAR)    && (w_rem != '0);
  assign busy        = (r_estado != IDLE);
  assign done        = (r_estado == DONE);
  assign err         = r_err;
  assign etapa       = r_estado;

endmodule
